// File: rtl/cpu_core_params.sv
// Core-wide datapath width and machine word type shared by the execution units.
package cpu_core_params;

    localparam int unsigned CPU_DATA_WIDTH = 32;

    typedef logic [CPU_DATA_WIDTH-1:0] CpuData;

endpackage

// File: rtl/mul_div_params.sv
// Operation and FSM state encodings for the HI/LO multiply/divide unit.
package mul_div_params;

    typedef enum logic [2:0] {
        MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MADDU
    } MulDivOp;

    typedef enum logic [1:0] {
        IDLE, MUL_WAIT, DIV_RUN
    } MulDivState;

endpackage

// File: rtl/divider_core.sv
// Radix-2 restoring divider on operand magnitudes: 32 step cycles, then a sign-fix cycle
// in which done is high and quotient/remainder carry the signed result.
module divider_core
    import cpu_core_params::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   kill,
    input  logic   start,
    input  logic   signed_op,
    input  CpuData dividend,
    input  CpuData divisor,
    output logic   done,
    output CpuData quotient,
    output CpuData remainder
);

    localparam int unsigned CountW = $clog2(CPU_DATA_WIDTH) + 1;
    localparam logic [CountW-1:0] LastCount = CountW'(CPU_DATA_WIDTH);

    logic                    active_q;
    logic [CountW-1:0]       count_q;
    CpuData                  quo_q;
    CpuData                  rem_q;
    CpuData                  dvs_q;
    logic                    neg_quo_q;
    logic                    neg_rem_q;
    logic                    dividend_neg;
    logic                    divisor_neg;
    logic [CPU_DATA_WIDTH:0] shifted;
    logic [CPU_DATA_WIDTH:0] diff;

    assign dividend_neg = signed_op & dividend[CPU_DATA_WIDTH-1];
    assign divisor_neg  = signed_op & divisor[CPU_DATA_WIDTH-1];

    // Partial remainder stays below the divisor, so a clear borrow bit means "subtract fits".
    assign shifted = {rem_q, quo_q[CPU_DATA_WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    assign done      = active_q & (count_q == LastCount);
    assign quotient  = neg_quo_q ? -quo_q : quo_q;
    assign remainder = neg_rem_q ? -rem_q : rem_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active_q  <= 1'b0;
            count_q   <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (kill) begin
            active_q <= 1'b0;
            count_q  <= '0;
        end else if (start) begin
            active_q  <= 1'b1;
            count_q   <= '0;
            quo_q     <= dividend_neg ? -dividend : dividend;
            rem_q     <= '0;
            dvs_q     <= divisor_neg ? -divisor : divisor;
            neg_quo_q <= dividend_neg ^ divisor_neg;
            neg_rem_q <= dividend_neg;
        end else if (active_q) begin
            if (done) begin
                active_q <= 1'b0;
            end else begin
                count_q <= count_q + CountW'(1);
                if (!diff[CPU_DATA_WIDTH]) begin
                    rem_q <= diff[CPU_DATA_WIDTH-1:0];
                    quo_q <= {quo_q[CPU_DATA_WIDTH-2:0], 1'b1};
                end else begin
                    rem_q <= shifted[CPU_DATA_WIDTH-1:0];
                    quo_q <= {quo_q[CPU_DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit with an external pipelined multiplier and iterative divider.
// MUL_DIV_MADD_EN enables MADD/MADDU accumulation; otherwise they retire as no-ops.
module mul_div_unit
    import cpu_core_params::*;
    import mul_div_params::*;
#(
    parameter int unsigned MUL_LATENCY = 1  // must be at least 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  MulDivOp                     req_op,
    input  CpuData                      req_src1,
    input  CpuData                      req_src2,
    input  logic                        flush,
    output CpuData                      mul_input1,
    output CpuData                      mul_input2,
    output logic                        mul_is_signed,
    input  logic [2*CPU_DATA_WIDTH-1:0] mul_result,
    output CpuData                      hi,
    output CpuData                      lo,
    output logic                        busy
);

    localparam logic [7:0] MulWaitInit = 8'(MUL_LATENCY - 1);

    MulDivState                  state_q, state_d;
    logic [7:0]                  mul_cnt_q, mul_cnt_d;
    MulDivOp                     op_q, op_d;
    logic                        div_zero_q, div_zero_d;
    CpuData                      hi_q, hi_d, lo_q, lo_d;
    logic                        madd_en;
    logic                        accept;
    logic                        is_mul_req;
    logic                        is_div_req;
    logic                        mul_start;
    logic                        div_start;
    logic                        mul_write;
    logic                        div_write;
    logic                        div_done;
    CpuData                      div_quot;
    CpuData                      div_rem;
    logic [2*CPU_DATA_WIDTH-1:0] acc_sum;

`ifdef MUL_DIV_MADD_EN
    assign madd_en = 1'b1;
`else
    assign madd_en = 1'b0;
`endif

    assign req_ready  = (state_q == IDLE) & ~flush & ~reset;
    assign busy       = (state_q != IDLE);
    assign accept     = req_valid & req_ready;
    assign is_mul_req = (req_op == MULT) | (req_op == MULTU) |
                        (madd_en & ((req_op == MADD) | (req_op == MADDU)));
    assign is_div_req = (req_op == DIV) | (req_op == DIVU);
    assign mul_start  = accept & is_mul_req;
    // A zero divisor never starts the core; the FSM spends one DIV_RUN cycle and drops it.
    assign div_start  = accept & is_div_req & (req_src2 != '0);

    // Flush in the completion cycle suppresses the write.
    assign mul_write = (state_q == MUL_WAIT) & (mul_cnt_q == '0) & ~flush;
    assign div_write = (state_q == DIV_RUN) & div_done & ~div_zero_q & ~flush;
    assign acc_sum   = {hi_q, lo_q} + mul_result;

    divider_core u_divider (
        .clock     (clock),
        .reset     (reset),
        .kill      (flush),
        .start     (div_start),
        .signed_op (req_op == DIV),
        .dividend  (req_src1),
        .divisor   (req_src2),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mul_cnt_q  <= '0;
            op_q       <= MULT;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            mul_cnt_q  <= mul_cnt_d;
            op_q       <= op_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mul_cnt_d  = mul_cnt_q;
        op_d       = op_q;
        div_zero_d = div_zero_q;
        if (accept) begin
            op_d       = req_op;
            div_zero_d = (req_src2 == '0);
        end
        case (state_q)
            IDLE: begin
                if (mul_start) begin
                    state_d   = MUL_WAIT;
                    mul_cnt_d = MulWaitInit;
                end else if (accept && is_div_req) begin
                    state_d = DIV_RUN;
                end
            end
            MUL_WAIT: begin
                if (mul_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    mul_cnt_d = mul_cnt_q - 8'd1;
                end
            end
            DIV_RUN: begin
                if (div_zero_q || div_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (accept && (req_op == MTHI)) begin
            hi_d = req_src1;
        end
        if (accept && (req_op == MTLO)) begin
            lo_d = req_src1;
        end
        if (mul_write) begin
            {hi_d, lo_d} = ((op_q == MADD) || (op_q == MADDU)) ? acc_sum : mul_result;
        end
        if (div_write) begin
            hi_d = div_rem;
            lo_d = div_quot;
        end
    end

    always_comb begin
        mul_input1    = '0;
        mul_input2    = '0;
        mul_is_signed = 1'b0;
        if (mul_start) begin
            mul_input1    = req_src1;
            mul_input2    = req_src2;
            mul_is_signed = (req_op == MULT) | (req_op == MADD);
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
